// File: rtl/mac_pkg.sv
// Shared MAC datapath types and helpers.
//  mac_datatype        : element encoding carried by a packed operand word
//  MAC_SEQ_SLOT_W      : width of one decoder slot
//  mac_seq_state_t     : operand sequencer FSM states
//  mac_elem_width      : element width in bits for a datatype
//  mac_beats_per_word  : beats needed to issue one packed word
package mac_pkg;

    typedef enum logic [1:0] {
        MAC_DATATYPE_FP16 = 2'd0,
        MAC_DATATYPE_FP8  = 2'd1,
        MAC_DATATYPE_INT9 = 2'd2
    } mac_datatype;

    localparam int MAC_SEQ_SLOT_W = 16;

    typedef enum logic {
        SEQ_IDLE  = 1'b0,
        SEQ_ISSUE = 1'b1
    } mac_seq_state_t;

    // Integer mode keeps a 16-bit container; only FP8 packs tighter.
    function automatic int mac_elem_width(input mac_datatype dt);
        return (dt == MAC_DATATYPE_FP8) ? 8 : 16;
    endfunction

    function automatic int mac_beats_per_word(input mac_datatype dt, input int in_w,
                                              input int out_n);
        return (in_w / mac_elem_width(dt)) / out_n;
    endfunction

endpackage

// File: rtl/mac_seq_slot_extract.sv
// Combinational element selector for the operand sequencer.
//  i_word     : packed operand word, element 0 in the LSBs
//  i_datatype : datatype the word is interpreted with
//  i_beat     : beat index within the word
//  o_slots    : OUT_N zero-extended 16-bit slots, slot k in bits [16k+15:16k]
module mac_seq_slot_extract
    import mac_pkg::*;
#(
    parameter int IN_W   = 64,
    parameter int OUT_N  = 2,
    parameter int BEAT_W = 2
) (
    input  logic [IN_W-1:0]                 i_word,
    input  mac_datatype                     i_datatype,
    input  logic [BEAT_W-1:0]               i_beat,
    output logic [OUT_N*MAC_SEQ_SLOT_W-1:0] o_slots
);

    logic [IN_W-1:0] w_shift;
    int              w_idx;

    always_comb begin
        o_slots = '0;
        w_shift = '0;
        w_idx   = 0;
        for (int k = 0; k < OUT_N; k++) begin
            w_idx   = int'(i_beat) * OUT_N + k;
            w_shift = i_word >> (w_idx * mac_elem_width(i_datatype));
            case (i_datatype)
                MAC_DATATYPE_FP16: o_slots[k*MAC_SEQ_SLOT_W +: MAC_SEQ_SLOT_W] = w_shift[15:0];
                MAC_DATATYPE_FP8:  o_slots[k*MAC_SEQ_SLOT_W +: MAC_SEQ_SLOT_W] = {8'h00, w_shift[7:0]};
                // Integer value lives in [8:0]; upper container bits are dropped.
                default:           o_slots[k*MAC_SEQ_SLOT_W +: MAC_SEQ_SLOT_W] = {7'h00, w_shift[8:0]};
            endcase
        end
    end

endmodule

// File: rtl/mac_operand_sequencer.sv
// Unpacks packed operand words into OUT_N-slot beats for the MAC decoder bank and
// owns the datatype register so it only changes between words.
//  i_clk, i_reset                  : clock, synchronous active-high reset
//  i_cfg_valid/i_cfg_datatype      : datatype update request
//  o_cfg_ready                     : update accepted (IDLE only)
//  i_valid/i_data/i_last/o_ready   : packed word input handshake
//  o_valid/o_data/o_first/o_last   : beat output, accepted with i_ready
//  o_datatype                      : latched datatype driving all decoders
//
//  state | meaning
//  IDLE  | no word held; accepts config or a new word
//  ISSUE | issuing beats of the held word, one per i_ready
module mac_operand_sequencer
    import mac_pkg::*;
#(
    parameter int IN_W  = 64,
    parameter int OUT_N = 2
) (
    input  logic                            i_clk,
    input  logic                            i_reset,
    input  logic                            i_cfg_valid,
    input  mac_datatype                     i_cfg_datatype,
    output logic                            o_cfg_ready,
    input  logic                            i_valid,
    input  logic [IN_W-1:0]                 i_data,
    input  logic                            i_last,
    output logic                            o_ready,
    output logic                            o_valid,
    output mac_datatype                     o_datatype,
    output logic [OUT_N*MAC_SEQ_SLOT_W-1:0] o_data,
    output logic                            o_first,
    output logic                            o_last,
    input  logic                            i_ready
);

    localparam int BEAT_RANGE = IN_W / 8 / OUT_N;
    localparam int BEAT_W     = (BEAT_RANGE > 1) ? $clog2(BEAT_RANGE) : 1;

    mac_seq_state_t                  r_state;
    logic [IN_W-1:0]                 r_word;
    logic [BEAT_W-1:0]               r_beat;
    logic                            r_wlast;
    mac_datatype                     r_datatype;
    logic [OUT_N*MAC_SEQ_SLOT_W-1:0] r_data;
    logic                            r_first;
    logic                            r_last;

    mac_seq_state_t                  w_state_nxt;
    logic [IN_W-1:0]                 w_word_nxt;
    logic [BEAT_W-1:0]               w_beat_nxt;
    logic                            w_wlast_nxt;
    mac_datatype                     w_dt_nxt;
    logic [BEAT_W-1:0]               w_last_beat;
    logic [BEAT_W-1:0]               w_last_beat_nxt;
    logic [OUT_N*MAC_SEQ_SLOT_W-1:0] w_slots;

    assign w_last_beat     = BEAT_W'(mac_beats_per_word(r_datatype, IN_W, OUT_N) - 1);
    assign w_last_beat_nxt = BEAT_W'(mac_beats_per_word(w_dt_nxt, IN_W, OUT_N) - 1);

    always_comb begin
        w_state_nxt = r_state;
        w_word_nxt  = r_word;
        w_beat_nxt  = r_beat;
        w_wlast_nxt = r_wlast;
        w_dt_nxt    = r_datatype;
        o_ready     = 1'b0;
        o_cfg_ready = 1'b0;
        case (r_state)
            SEQ_IDLE: begin
                o_cfg_ready = 1'b1;
                // Config wins a tie; the word is taken the following cycle.
                o_ready     = !i_cfg_valid;
                if (i_cfg_valid) begin
                    w_dt_nxt = i_cfg_datatype;
                end else if (i_valid) begin
                    w_state_nxt = SEQ_ISSUE;
                    w_word_nxt  = i_data;
                    w_beat_nxt  = '0;
                    w_wlast_nxt = i_last;
                end
            end
            SEQ_ISSUE: begin
                if (i_ready) begin
                    if (r_beat == w_last_beat) begin
                        // Accept the next word on the final beat for zero-bubble streaming.
                        o_ready = 1'b1;
                        if (i_valid) begin
                            w_word_nxt  = i_data;
                            w_beat_nxt  = '0;
                            w_wlast_nxt = i_last;
                        end else begin
                            w_state_nxt = SEQ_IDLE;
                        end
                    end else begin
                        w_beat_nxt = r_beat + 1'b1;
                    end
                end
            end
            default: w_state_nxt = SEQ_IDLE;
        endcase
    end

    // Outputs are registered from next-state values so a stalled beat holds exactly.
    mac_seq_slot_extract #(
        .IN_W   (IN_W),
        .OUT_N  (OUT_N),
        .BEAT_W (BEAT_W)
    ) u_extract (
        .i_word     (w_word_nxt),
        .i_datatype (w_dt_nxt),
        .i_beat     (w_beat_nxt),
        .o_slots    (w_slots)
    );

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state    <= SEQ_IDLE;
            r_word     <= '0;
            r_beat     <= '0;
            r_wlast    <= 1'b0;
            r_datatype <= MAC_DATATYPE_FP16;
            r_data     <= '0;
            r_first    <= 1'b0;
            r_last     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_word     <= w_word_nxt;
            r_beat     <= w_beat_nxt;
            r_wlast    <= w_wlast_nxt;
            r_datatype <= w_dt_nxt;
            if (w_state_nxt == SEQ_ISSUE) begin
                r_data  <= w_slots;
                r_first <= (w_beat_nxt == '0);
                r_last  <= w_wlast_nxt && (w_beat_nxt == w_last_beat_nxt);
            end else begin
                r_data  <= '0;
                r_first <= 1'b0;
                r_last  <= 1'b0;
            end
        end
    end

    assign o_valid    = (r_state == SEQ_ISSUE);
    assign o_datatype = r_datatype;
    assign o_data     = r_data;
    assign o_first    = r_first;
    assign o_last     = r_last;

endmodule

// File: tb/tb_mac_operand_sequencer.sv
module tb_mac_operand_sequencer;
    import mac_pkg::*;

    logic        clk = 1'b0;
    logic        i_reset;
    logic        i_cfg_valid;
    mac_datatype i_cfg_datatype;
    logic        o_cfg_ready;
    logic        i_valid;
    logic [63:0] i_data;
    logic        i_last;
    logic        o_ready;
    logic        o_valid;
    mac_datatype o_datatype;
    logic [31:0] o_data;
    logic        o_first;
    logic        o_last;
    logic        i_ready;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mac_operand_sequencer #(.IN_W(64), .OUT_N(2)) dut (
        .i_clk          (clk),
        .i_reset        (i_reset),
        .i_cfg_valid    (i_cfg_valid),
        .i_cfg_datatype (i_cfg_datatype),
        .o_cfg_ready    (o_cfg_ready),
        .i_valid        (i_valid),
        .i_data         (i_data),
        .i_last         (i_last),
        .o_ready        (o_ready),
        .o_valid        (o_valid),
        .o_datatype     (o_datatype),
        .o_data         (o_data),
        .o_first        (o_first),
        .o_last         (o_last),
        .i_ready        (i_ready)
    );

    task automatic test_reset();
        @(negedge clk);
        i_reset = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got=%0b exp=0", o_valid); end
        checks++; if (o_data !== 32'h0) begin errors++; $display("FAIL rst_data got=%h exp=0", o_data); end
        checks++; if (o_first !== 1'b0 || o_last !== 1'b0) begin errors++; $display("FAIL rst_first_last got=%0b%0b exp=00", o_first, o_last); end
        checks++; if (o_datatype !== MAC_DATATYPE_FP16) begin errors++; $display("FAIL rst_datatype got=%0d exp=%0d", o_datatype, MAC_DATATYPE_FP16); end
        checks++; if (o_ready !== 1'b1 || o_cfg_ready !== 1'b1) begin errors++; $display("FAIL rst_readies got=%0b%0b exp=11", o_ready, o_cfg_ready); end
        i_reset = 1'b0;
    endtask

    task automatic test_fp16();
        i_ready = 1'b1;
        i_valid = 1'b1;
        i_data  = 64'h4400_3C00_C000_0000;
        i_last  = 1'b1;
        #1;
        checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL fp16_accept_ready got=%0b exp=1", o_ready); end
        @(negedge clk);
        i_valid = 1'b0;
        checks++; if (o_valid !== 1'b1) begin errors++; $display("FAIL fp16_b0_valid got=%0b exp=1", o_valid); end
        checks++; if (o_data !== 32'hC000_0000) begin errors++; $display("FAIL fp16_b0_data got=%h exp=c0000000", o_data); end
        checks++; if (o_first !== 1'b1 || o_last !== 1'b0) begin errors++; $display("FAIL fp16_b0_flags got=%0b%0b exp=10", o_first, o_last); end
        #1;
        checks++; if (o_ready !== 1'b0) begin errors++; $display("FAIL fp16_b0_ready got=%0b exp=0", o_ready); end
        @(negedge clk);
        checks++; if (o_data !== 32'h4400_3C00) begin errors++; $display("FAIL fp16_b1_data got=%h exp=44003c00", o_data); end
        checks++; if (o_first !== 1'b0 || o_last !== 1'b1) begin errors++; $display("FAIL fp16_b1_flags got=%0b%0b exp=01", o_first, o_last); end
        #1;
        checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL fp16_b1_ready got=%0b exp=1", o_ready); end
        @(negedge clk);
        checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL fp16_idle_valid got=%0b exp=0", o_valid); end
    endtask

    task automatic test_fp8_cfg();
        logic [31:0] exp_data;
        i_cfg_valid    = 1'b1;
        i_cfg_datatype = MAC_DATATYPE_FP8;
        i_valid        = 1'b1;
        i_data         = 64'h0807_0605_0403_0201;
        i_last         = 1'b0;
        #1;
        checks++; if (o_cfg_ready !== 1'b1 || o_ready !== 1'b0) begin errors++; $display("FAIL cfg_priority got=cfg%0b rdy%0b exp=cfg1 rdy0", o_cfg_ready, o_ready); end
        @(negedge clk);
        i_cfg_valid = 1'b0;
        checks++; if (o_datatype !== MAC_DATATYPE_FP8) begin errors++; $display("FAIL cfg_fp8_latched got=%0d exp=%0d", o_datatype, MAC_DATATYPE_FP8); end
        checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL cfg_cycle_valid got=%0b exp=0", o_valid); end
        #1;
        checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL cfg_then_ready got=%0b exp=1", o_ready); end
        @(negedge clk);
        i_valid        = 1'b0;
        i_cfg_valid    = 1'b1;
        i_cfg_datatype = MAC_DATATYPE_INT9;
        for (int b = 0; b < 4; b++) begin
            exp_data = {16'(2 * b + 2), 16'(2 * b + 1)};
            checks++; if (o_valid !== 1'b1 || o_data !== exp_data) begin errors++; $display("FAIL fp8_beat%0d got=v%0b %h exp=v1 %h", b, o_valid, o_data, exp_data); end
            checks++; if (o_first !== (b == 0) || o_last !== 1'b0) begin errors++; $display("FAIL fp8_flags%0d got=%0b%0b exp=%0b0", b, o_first, o_last, (b == 0)); end
            checks++; if (o_datatype !== MAC_DATATYPE_FP8) begin errors++; $display("FAIL fp8_dt_hold%0d got=%0d exp=%0d", b, o_datatype, MAC_DATATYPE_FP8); end
            #1;
            checks++; if (o_cfg_ready !== 1'b0) begin errors++; $display("FAIL fp8_cfg_blocked%0d got=%0b exp=0", b, o_cfg_ready); end
            @(negedge clk);
        end
        checks++; if (o_valid !== 1'b0 || o_datatype !== MAC_DATATYPE_FP8) begin errors++; $display("FAIL fp8_end got=v%0b dt%0d exp=v0 dt%0d", o_valid, o_datatype, MAC_DATATYPE_FP8); end
        #1;
        checks++; if (o_cfg_ready !== 1'b1) begin errors++; $display("FAIL cfg_idle_ready got=%0b exp=1", o_cfg_ready); end
        @(negedge clk);
        i_cfg_valid = 1'b0;
        checks++; if (o_datatype !== MAC_DATATYPE_INT9) begin errors++; $display("FAIL cfg_int_latched got=%0d exp=%0d", o_datatype, MAC_DATATYPE_INT9); end
    endtask

    task automatic test_back_to_back_int_stall();
        i_ready = 1'b1;
        i_valid = 1'b1;
        i_data  = 64'hFFFF_FFFF_FFFF_FFFF;
        i_last  = 1'b0;
        @(negedge clk);
        checks++; if (o_valid !== 1'b1 || o_data !== 32'h01FF_01FF || o_first !== 1'b1) begin errors++; $display("FAIL int_a0 got=v%0b %h f%0b exp=v1 01ff01ff f1", o_valid, o_data, o_first); end
        i_data = 64'h0123_0456_0789_0ABC;
        i_last = 1'b1;
        #1;
        checks++; if (o_ready !== 1'b0) begin errors++; $display("FAIL int_a0_ready got=%0b exp=0", o_ready); end
        @(negedge clk);
        checks++; if (o_data !== 32'h01FF_01FF || o_first !== 1'b0 || o_last !== 1'b0) begin errors++; $display("FAIL int_a1 got=%h f%0b l%0b exp=01ff01ff f0 l0", o_data, o_first, o_last); end
        #1;
        checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL int_a1_ready got=%0b exp=1", o_ready); end
        @(negedge clk);
        i_valid = 1'b0;
        checks++; if (o_valid !== 1'b1 || o_data !== 32'h0189_00BC || o_first !== 1'b1) begin errors++; $display("FAIL int_b0_nobubble got=v%0b %h f%0b exp=v1 018900bc f1", o_valid, o_data, o_first); end
        @(negedge clk);
        checks++; if (o_data !== 32'h0123_0056 || o_last !== 1'b1) begin errors++; $display("FAIL int_b1 got=%h l%0b exp=01230056 l1", o_data, o_last); end
        i_ready = 1'b0;
        #1;
        checks++; if (o_ready !== 1'b0) begin errors++; $display("FAIL stall_ready0 got=%0b exp=0", o_ready); end
        for (int s = 0; s < 3; s++) begin
            @(negedge clk);
            checks++; if (o_valid !== 1'b1 || o_data !== 32'h0123_0056 || o_last !== 1'b1 || o_ready !== 1'b0) begin errors++; $display("FAIL stall%0d got=v%0b %h l%0b r%0b exp=v1 01230056 l1 r0", s, o_valid, o_data, o_last, o_ready); end
        end
        i_ready = 1'b1;
        #1;
        checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL stall_release_ready got=%0b exp=1", o_ready); end
        @(negedge clk);
        checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL int_idle got=%0b exp=0", o_valid); end
    endtask

    task automatic test_reset_mid_word();
        i_cfg_valid    = 1'b1;
        i_cfg_datatype = MAC_DATATYPE_FP8;
        @(negedge clk);
        i_cfg_valid = 1'b0;
        i_valid     = 1'b1;
        i_data      = 64'h0807_0605_0403_0201;
        i_last      = 1'b1;
        i_ready     = 1'b1;
        @(negedge clk);
        i_valid = 1'b0;
        checks++; if (o_data !== 32'h0002_0001) begin errors++; $display("FAIL rmw_b0 got=%h exp=00020001", o_data); end
        @(negedge clk);
        checks++; if (o_data !== 32'h0004_0003) begin errors++; $display("FAIL rmw_b1 got=%h exp=00040003", o_data); end
        i_reset = 1'b1;
        @(negedge clk);
        i_reset = 1'b0;
        checks++; if (o_valid !== 1'b0 || o_data !== 32'h0 || o_first !== 1'b0) begin errors++; $display("FAIL rmw_cleared got=v%0b %h f%0b exp=v0 0 f0", o_valid, o_data, o_first); end
        checks++; if (o_datatype !== MAC_DATATYPE_FP16) begin errors++; $display("FAIL rmw_datatype got=%0d exp=%0d", o_datatype, MAC_DATATYPE_FP16); end
        @(negedge clk);
        checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL rmw_discard got=%0b exp=0", o_valid); end
    endtask

    initial begin
        i_reset        = 1'b1;
        i_cfg_valid    = 1'b0;
        i_cfg_datatype = MAC_DATATYPE_FP16;
        i_valid        = 1'b0;
        i_data         = '0;
        i_last         = 1'b0;
        i_ready        = 1'b0;
        test_reset();
        test_fp16();
        test_fp8_cfg();
        test_back_to_back_int_stall();
        test_reset_mid_word();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
